// File: rtl/bytewrite_tdp_ram.sv
// True dual-port RAM with per-column byte enables on a single clock.
// Each port independently selects write-first, read-first or no-change
// output behaviour, and the read path can be one or two registers deep.
// On a same-address, same-column write collision port A's data is kept.
module bytewrite_tdp_ram #(
  parameter int NUM_COL      = 4,
  parameter int COL_WIDTH    = 8,
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = NUM_COL * COL_WIDTH,
  parameter int WRITE_MODE_A = 0,
  parameter int WRITE_MODE_B = 0,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena_a,
  input  logic [NUM_COL-1:0]    we_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] din_a,
  output logic [DATA_WIDTH-1:0] dout_a,
  output logic                  valid_a,
  input  logic                  ena_b,
  input  logic [NUM_COL-1:0]    we_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] din_b,
  output logic [DATA_WIDTH-1:0] dout_b,
  output logic                  valid_b
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("bytewrite_tdp_ram: READ_LATENCY must be 1 or 2");
  end
  if (WRITE_MODE_A < 0 || WRITE_MODE_A > 2) begin : g_bad_mode_a
    $error("bytewrite_tdp_ram: WRITE_MODE_A must be 0, 1 or 2");
  end
  if (WRITE_MODE_B < 0 || WRITE_MODE_B > 2) begin : g_bad_mode_b
    $error("bytewrite_tdp_ram: WRITE_MODE_B must be 0, 1 or 2");
  end
  if (NUM_COL == 0 || COL_WIDTH == 0) begin : g_bad_geom
    $error("bytewrite_tdp_ram: NUM_COL and COL_WIDTH must be non-zero");
  end

  // Output word for an access: write-first substitutes the written columns,
  // read-first and no-change (when reading) return the pre-edge word.
  function automatic logic [DATA_WIDTH-1:0] merge_rd(
    input int                    mode,
    input logic [NUM_COL-1:0]    we,
    input logic [DATA_WIDTH-1:0] din,
    input logic [DATA_WIDTH-1:0] old
  );
    logic [DATA_WIDTH-1:0] res;
    res = old;
    if (mode == 0) begin
      for (int c = 0; c < NUM_COL; c++) begin
        if (we[c]) res[c*COL_WIDTH +: COL_WIDTH] = din[c*COL_WIDTH +: COL_WIDTH];
      end
    end
    return res;
  endfunction

  logic [DATA_WIDTH-1:0] r_ram [DEPTH];

  logic [DATA_WIDTH-1:0] w_old_a;
  logic [DATA_WIDTH-1:0] w_old_b;
  logic                  w_acc_a;
  logic                  w_acc_b;

  // Pre-edge memory words; the output registers sample these so that both
  // own-port and cross-port reads see content from before this edge's writes.
  assign w_old_a = r_ram[addr_a];
  assign w_old_b = r_ram[addr_b];

  // A no-change port produces no output for an enabled write.
  assign w_acc_a = ena_a && !(WRITE_MODE_A == 2 && (|we_a));
  assign w_acc_b = ena_b && !(WRITE_MODE_B == 2 && (|we_b));

  // Column writes; B is issued first so A's assignment wins a collision.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int c = 0; c < NUM_COL; c++) begin
        if (ena_b && we_b[c]) r_ram[addr_b][c*COL_WIDTH +: COL_WIDTH] <= din_b[c*COL_WIDTH +: COL_WIDTH];
        if (ena_a && we_a[c]) r_ram[addr_a][c*COL_WIDTH +: COL_WIDTH] <= din_a[c*COL_WIDTH +: COL_WIDTH];
      end
    end
  end

  // ---- stage p1: first output register, loads only on a qualifying access
  logic [DATA_WIDTH-1:0] r_dout_a_p1;
  logic [DATA_WIDTH-1:0] r_dout_b_p1;
  logic                  r_vld_a_p1;
  logic                  r_vld_b_p1;

  // Port A output register and one-cycle valid pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout_a_p1 <= '0;
      r_vld_a_p1  <= 1'b0;
    end else begin
      r_vld_a_p1 <= w_acc_a;
      if (w_acc_a) r_dout_a_p1 <= merge_rd(WRITE_MODE_A, we_a, din_a, w_old_a);
    end
  end

  // Port B output register and one-cycle valid pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout_b_p1 <= '0;
      r_vld_b_p1  <= 1'b0;
    end else begin
      r_vld_b_p1 <= w_acc_b;
      if (w_acc_b) r_dout_b_p1 <= merge_rd(WRITE_MODE_B, we_b, din_b, w_old_b);
    end
  end

  // ---- stage p2: optional free-running output register
  if (READ_LATENCY == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] r_dout_a_p2;
    logic [DATA_WIDTH-1:0] r_dout_b_p2;
    logic                  r_vld_a_p2;
    logic                  r_vld_b_p2;

    // Delay both ports' data and valid by one more edge.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_dout_a_p2 <= '0;
        r_dout_b_p2 <= '0;
        r_vld_a_p2  <= 1'b0;
        r_vld_b_p2  <= 1'b0;
      end else begin
        r_dout_a_p2 <= r_dout_a_p1;
        r_dout_b_p2 <= r_dout_b_p1;
        r_vld_a_p2  <= r_vld_a_p1;
        r_vld_b_p2  <= r_vld_b_p1;
      end
    end

    assign dout_a  = r_dout_a_p2;
    assign dout_b  = r_dout_b_p2;
    assign valid_a = r_vld_a_p2;
    assign valid_b = r_vld_b_p2;
  end else begin : g_lat1
    assign dout_a  = r_dout_a_p1;
    assign dout_b  = r_dout_b_p1;
    assign valid_a = r_vld_a_p1;
    assign valid_b = r_vld_b_p1;
  end

endmodule

// File: doc/bytewrite_tdp_ram.md
BYTEWRITE_TDP_RAM -- requirements
Module: bytewrite_tdp_ram

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- NUM_COL, 4: byte-enable columns per word.
- COL_WIDTH, 8: bits per column.
- ADDR_WIDTH, 10: address bits; depth is 2**ADDR_WIDTH.
- DATA_WIDTH, NUM_COL*COL_WIDTH: word width (derived).
- WRITE_MODE_A, 0: port A mode; 0 write-first, 1 read-first, 2 no-change.
- WRITE_MODE_B, 0: port B mode; encoding as WRITE_MODE_A.
- READ_LATENCY, 1: clocks from enable to data, 1 or 2.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: single clock; all logic is on the rising edge.
- rst, in, 1: asynchronous, active-high reset.
- ena_a, in, 1: port A access enable.
- we_a, in, NUM_COL: port A per-column write enable.
- addr_a, in, ADDR_WIDTH: port A address.
- din_a, in, DATA_WIDTH: port A write data.
- dout_a, out, DATA_WIDTH: port A read data (registered).
- valid_a, out, 1: dout_a updated this cycle.
- ena_b, we_b, addr_b, din_b, dout_b, valid_b: port B equivalents, same widths.
REQ-003 Parameter checks SHALL fail elaboration when READ_LATENCY is not 1 or 2, when WRITE_MODE_A or WRITE_MODE_B is greater than 2, or when NUM_COL or COL_WIDTH is 0.

Function
REQ-004 When ena_x=1 and we_x[i]=1, column i of ram[addr_x] SHALL take din_x[i*COL_WIDTH +: COL_WIDTH] at the clock edge; when ena_x=0, port x SHALL do nothing.
REQ-005 A write-first port (mode 0) SHALL load each dout column from din where we[i]=1, and from the pre-edge memory content where we[i]=0.
REQ-006 A read-first port (mode 1) SHALL load all dout columns from the pre-edge memory content, whatever we is.
REQ-007 A no-change port (mode 2) SHALL hold dout and SHALL NOT pulse valid in any enabled cycle with we != 0; when we=0 it SHALL read as mode 1.
REQ-008 With READ_LATENCY=1, dout_x and valid_x SHALL update at the edge that samples ena_x.
REQ-009 With READ_LATENCY=2, data SHALL pass through one more free-running register, so dout_x and valid_x appear one edge later.
REQ-010 valid_x SHALL be a one-cycle pulse per qualifying access, aligned with dout_x; between pulses dout_x SHALL hold its last value.
REQ-011 Write collision (both ports enabled, addr_a=addr_b, both enables set for column i): port A data SHALL be stored in that column. Columns written by only one port SHALL take that port's data.
REQ-012 Cross-port read during write (same address, port y reads column i that port x writes and y does not): y SHALL return the pre-edge content of that column.
REQ-013 Wrap-around: any address value is legal and there SHALL be no aliasing between distinct addresses.
REQ-014 Ports SHALL be fully independent when their addresses differ; throughput SHALL be one access per port per clock.

Reset
REQ-015 Asserting rst SHALL immediately clear dout_a, dout_b, valid_a, valid_b and every READ_LATENCY=2 pipeline register to 0.
REQ-016 While rst=1, no write SHALL reach memory and no valid pulse SHALL occur; accesses in flight when rst asserts SHALL be discarded.
REQ-017 Memory contents SHALL NOT be cleared by rst; contents written before reset SHALL remain readable after reset.
REQ-018 The first access SHALL be accepted at the first rising edge after rst deasserts.

Verification
REQ-019 Defaults, mode 0: write A addr 5 we=4'b0101 din=32'hAABBCCDD over 32'h11223344 -> dout_a=32'h11BB33DD; one cycle later, valid_a=1.
REQ-020 Port B mode 1: write addr 7 din=32'hDEADBEEF over 32'h0 -> dout_b=32'h0; next read of addr 7 -> 32'hDEADBEEF.
REQ-021 Port A mode 2: read addr 3 gives X, then a write of any we != 0 -> dout_a holds X and valid_a stays 0 during the write cycle.
REQ-022 Collision at addr 9: A we=4'b0011 din=32'h11111111, B we=4'b0110 din=32'h22222222, old word 0 -> ram[9]=32'h00221111.
REQ-023 READ_LATENCY=2, back-to-back reads of addrs 0,1,2 -> valid_a high on cycles 2,3,4 with data in order; rst pulsed mid-stream -> outputs 0 immediately and stored data preserved.
